// File: rtl/hx8357_pkg.sv
// Shared types and constants for the HX8357 command/pixel sequencer.
//   state_e        sequencer states
//   DCS_*          display command opcodes
//   rom_word_t     instruction ROM entry layout for the default image
//   DEFAULT_INIT_ROM  default power-up script, zero-padded to 64 entries
package hx8357_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_WIN,
    ST_PIX
  } state_e;

  localparam logic [7:0] DCS_NOP     = 8'h00;
  localparam logic [7:0] DCS_SWRESET = 8'h01;
  localparam logic [7:0] DCS_SLPOUT  = 8'h11;
  localparam logic [7:0] DCS_DISPON  = 8'h29;
  localparam logic [7:0] DCS_CASET   = 8'h2A;
  localparam logic [7:0] DCS_PASET   = 8'h2B;
  localparam logic [7:0] DCS_RAMWR   = 8'h2C;
  localparam logic [7:0] DCS_TEON    = 8'h35;
  localparam logic [7:0] DCS_MADCTL  = 8'h36;
  localparam logic [7:0] DCS_COLMOD  = 8'h3A;
  localparam logic [7:0] DCS_TEARLN  = 8'h44;

  localparam int unsigned DEF_ROM_AW   = 6;
  localparam int unsigned DEF_DELAY_W  = 7;
  localparam int unsigned DEF_N_INST   = 48;
  localparam int unsigned DEF_ROM_DW   = 1 + 8 + DEF_DELAY_W;
  localparam int unsigned DEF_ROM_BITS = (2 ** DEF_ROM_AW) * DEF_ROM_DW;

  typedef struct packed {
    logic                   is_cmd;
    logic [7:0]             dat;
    logic [DEF_DELAY_W-1:0] delay;
  } rom_word_t;

  // Builds the default script; unused tail entries are NOP commands.
  function automatic logic [DEF_ROM_BITS-1:0] default_init_rom();
    logic [DEF_ROM_BITS-1:0] img;
    rom_word_t               w;
    img = '0;
    for (int i = 0; i < int'(DEF_N_INST); i++) begin
      case (i)
        0:       w = {1'b1, DCS_SWRESET, 7'd1};
        1:       w = {1'b1, DCS_SLPOUT,  7'd8};
        2:       w = {1'b1, DCS_COLMOD,  7'd0};
        3:       w = {1'b0, 8'h55,       7'd0};
        4:       w = {1'b1, DCS_MADCTL,  7'd0};
        5:       w = {1'b0, 8'h00,       7'd0};
        6:       w = {1'b1, DCS_TEON,    7'd0};
        7:       w = {1'b0, 8'h00,       7'd0};
        8:       w = {1'b1, DCS_TEARLN,  7'd0};
        9:       w = {1'b0, 8'h00,       7'd0};
        10:      w = {1'b0, 8'h02,       7'd0};
        11:      w = {1'b1, DCS_DISPON,  7'd1};
        default: w = {1'b1, DCS_NOP,     7'd0};
      endcase
      img[i*int'(DEF_ROM_DW) +: DEF_ROM_DW] = w;
    end
    return img;
  endfunction

  localparam logic [DEF_ROM_BITS-1:0] DEFAULT_INIT_ROM = default_init_rom();

endpackage

// File: rtl/instruction_rom.sv
// Instruction ROM with one-cycle registered read.
//   clk   in   clock
//   addr  in   entry address
//   q     out  entry contents, valid the cycle after addr is presented
module instruction_rom #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6,
  parameter logic [(2**AW)*DW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    q <= INIT[int'(addr)*int'(DW) +: DW];
  end

endmodule

// File: rtl/hx8357_seq_ctrl.sv
// HX8357 command/pixel sequencer: replays the ROM init script with per-entry
// delays, then serves rectangle fills (CASET, PASET, RAMWR, N colour words).
//   clk, res                         clock, synchronous active-high reset
//   start_init, fill_req             request pulses, honoured in IDLE only
//   fill_x0/x1/y0/y1, fill_color     rectangle (inclusive) and pixel word
//   out_valid/out_ready/out_cmd/out_word  word stream to the bus controller
//   busy, init_done, fill_err        status
module hx8357_seq_ctrl
  import hx8357_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ROM_AW      = 6,
  parameter int unsigned N_INST      = 48,
  parameter int unsigned DELAY_W     = 7,
  parameter int unsigned DELAY_SHIFT = 14,
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 480,
  parameter logic [(2**ROM_AW)*(9+DELAY_W)-1:0] ROM_INIT = DEFAULT_INIT_ROM
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start_init,
  input  logic              fill_req,
  input  logic [8:0]        fill_x0,
  input  logic [8:0]        fill_x1,
  input  logic [8:0]        fill_y0,
  input  logic [8:0]        fill_y1,
  input  logic [DATA_W-1:0] fill_color,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_cmd,
  output logic [DATA_W-1:0] out_word,
  output logic              busy,
  output logic              init_done,
  output logic              fill_err
);

  localparam int unsigned ROM_DW   = 1 + 8 + DELAY_W;
  localparam int unsigned WAIT_W   = DELAY_W + DELAY_SHIFT;
  localparam int unsigned PIX_W    = $clog2(H_RES * V_RES);
  localparam int unsigned COORD_W  = 9;
  localparam logic [ROM_AW-1:0] LAST_INST = ROM_AW'(N_INST - 1);
  localparam logic [3:0]        WIN_LAST  = 4'd10;

  state_e               state_q, state_d;
  logic [ROM_AW-1:0]    inst_cnt_q, inst_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]           win_idx_q, win_idx_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [COORD_W-1:0]   x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [DATA_W-1:0]    color_q, color_d;
  logic                 init_done_q, init_done_d;
  logic                 fill_err_q, fill_err_d;

  logic [ROM_DW-1:0]    rom_q;
  logic                 rom_is_cmd;
  logic [7:0]           rom_byte;
  logic [DELAY_W-1:0]   rom_delay;
  logic [WAIT_W-1:0]    wait_tc;
  logic [7:0]           win_byte;
  logic [PIX_W-1:0]     pix_dx, pix_dy, pix_total;
  logic                 rect_ok;
  logic                 xfer;

  // Address is held stable across FETCH/ISSUE/WAIT so rom_q stays valid.
  instruction_rom #(
    .DW   (ROM_DW),
    .AW   (ROM_AW),
    .INIT (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (inst_cnt_q),
    .q    (rom_q)
  );

  assign rom_is_cmd = rom_q[ROM_DW-1];
  assign rom_byte   = rom_q[DELAY_W +: 8];
  assign rom_delay  = rom_q[DELAY_W-1:0];
  assign wait_tc    = (WAIT_W'(rom_delay) << DELAY_SHIFT) - WAIT_W'(1);
  assign xfer       = out_valid & out_ready;

  assign rect_ok = (fill_x0 <= fill_x1) && (32'(fill_x1) < H_RES) &&
                   (fill_y0 <= fill_y1) && (32'(fill_y1) < V_RES);

  // Pixel count minus one, preloaded into the down-counter.
  assign pix_dx    = PIX_W'(x1_q) - PIX_W'(x0_q) + PIX_W'(1);
  assign pix_dy    = PIX_W'(y1_q) - PIX_W'(y0_q) + PIX_W'(1);
  assign pix_total = pix_dx * pix_dy - PIX_W'(1);

  // Window-setup script byte for the current index.
  always_comb begin
    win_byte = 8'h00;
    case (win_idx_q)
      4'd0:    win_byte = DCS_CASET;
      4'd1:    win_byte = {7'd0, x0_q[8]};
      4'd2:    win_byte = x0_q[7:0];
      4'd3:    win_byte = {7'd0, x1_q[8]};
      4'd4:    win_byte = x1_q[7:0];
      4'd5:    win_byte = DCS_PASET;
      4'd6:    win_byte = {7'd0, y0_q[8]};
      4'd7:    win_byte = y0_q[7:0];
      4'd8:    win_byte = {7'd0, y1_q[8]};
      4'd9:    win_byte = y1_q[7:0];
      4'd10:   win_byte = DCS_RAMWR;
      default: win_byte = 8'h00;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      inst_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      win_idx_q   <= '0;
      pix_cnt_q   <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      init_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_cnt_q  <= inst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      win_idx_q   <= win_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      init_done_q <= init_done_d;
      fill_err_q  <= fill_err_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    inst_cnt_d  = inst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    win_idx_d   = win_idx_q;
    pix_cnt_d   = pix_cnt_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    init_done_d = init_done_q;
    fill_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_init) begin
          state_d     = ST_FETCH;
          inst_cnt_d  = '0;
          init_done_d = 1'b0;
        end else if (fill_req && init_done_q) begin
          if (rect_ok) begin
            state_d   = ST_WIN;
            win_idx_d = '0;
            x0_d      = fill_x0;
            x1_d      = fill_x1;
            y0_d      = fill_y0;
            y1_d      = fill_y1;
            color_d   = fill_color;
          end else begin
            fill_err_d = 1'b1;
          end
        end
      end

      ST_FETCH: state_d = ST_ISSUE;

      ST_ISSUE: begin
        if (xfer) begin
          if (rom_delay != '0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end else if (inst_cnt_q == LAST_INST) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            inst_cnt_d = inst_cnt_q + ROM_AW'(1);
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == wait_tc) begin
          if (inst_cnt_q == LAST_INST) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            inst_cnt_d = inst_cnt_q + ROM_AW'(1);
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_WIN: begin
        if (xfer) begin
          if (win_idx_q == WIN_LAST) begin
            state_d   = ST_PIX;
            pix_cnt_d = pix_total;
          end else begin
            win_idx_d = win_idx_q + 4'd1;
          end
        end
      end

      ST_PIX: begin
        if (xfer) begin
          if (pix_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q - PIX_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    out_valid = 1'b0;
    out_cmd   = 1'b0;
    out_word  = '0;
    case (state_q)
      ST_ISSUE: begin
        out_valid = 1'b1;
        out_cmd   = rom_is_cmd;
        out_word  = DATA_W'(rom_byte);
      end
      ST_WIN: begin
        out_valid = 1'b1;
        out_cmd   = (win_idx_q == 4'd0) || (win_idx_q == 4'd5) || (win_idx_q == WIN_LAST);
        out_word  = DATA_W'(win_byte);
      end
      ST_PIX: begin
        out_valid = 1'b1;
        out_word  = color_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign init_done = init_done_q;
  assign fill_err  = fill_err_q;

endmodule

// File: tb/tb_hx8357_seq_ctrl.sv
// Directed bench for hx8357_seq_ctrl: a two-entry init script with a short
// delay, window/pixel fills, rejected rectangles, stalls, reset and
// request-priority cases.
module tb_hx8357_seq_ctrl;

  localparam logic [1023:0] TB_ROM = {992'd0, 1'b1, 8'h29, 7'd0, 1'b1, 8'h11, 7'd5};

  logic        clk;
  logic        res;
  logic        start_init;
  logic        fill_req;
  logic [8:0]  fill_x0, fill_x1, fill_y0, fill_y1;
  logic [15:0] fill_color;
  logic        out_valid;
  logic        out_ready;
  logic        out_cmd;
  logic [15:0] out_word;
  logic        busy;
  logic        init_done;
  logic        fill_err;

  int n_asserts = 0;
  int n_fail    = 0;

  hx8357_seq_ctrl #(
    .DATA_W      (16),
    .ROM_AW      (6),
    .N_INST      (2),
    .DELAY_W     (7),
    .DELAY_SHIFT (2),
    .H_RES       (320),
    .V_RES       (24),
    .ROM_INIT    (TB_ROM)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start_init (start_init),
    .fill_req   (fill_req),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cmd    (out_cmd),
    .out_word   (out_word),
    .busy       (busy),
    .init_done  (init_done),
    .fill_err   (fill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a transfer, check the word, then let it complete.
  task automatic expect_word(input string tag, input logic cmd, input logic [15:0] word);
    int n;
    n = 0;
    while (!(out_valid && out_ready) && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_xfer"}, 32'(out_valid & out_ready), 32'd1);
    chk({tag, "_cmd"}, 32'(out_cmd), 32'(cmd));
    chk({tag, "_word"}, 32'(out_word), 32'(word));
    step();
  endtask

  task automatic set_rect(input logic [8:0] x0, input logic [8:0] x1,
                          input logic [8:0] y0, input logic [8:0] y1,
                          input logic [15:0] c);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
  endtask

  logic [15:0] exp_words [0:10];

  initial begin
    int gap, xfers, pix, bad, n_data;
    logic prev_stall, pc;
    logic [15:0] pw;

    res = 1'b1; start_init = 1'b0; fill_req = 1'b0; out_ready = 1'b1;
    set_rect(9'd0, 9'd0, 9'd0, 9'd0, 16'h0000);
    step();
    step();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_fill_err", 32'(fill_err), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_cmd", 32'(out_cmd), 32'd0);
    res = 1'b0;
    step();

    // T6: fill before init is ignored without an error pulse
    set_rect(9'd0, 9'd1, 9'd0, 9'd1, 16'h1234);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    chk("t6_fill_err", 32'(fill_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    step();
    chk("t6_busy2", 32'(busy), 32'd0);

    // T1: init script, 2-cycle latency, 20 WAIT cycles plus one FETCH gap
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    chk("t1_fetch_valid", 32'(out_valid), 32'd0);
    chk("t1_fetch_busy", 32'(busy), 32'd1);
    step();
    chk("t1_issue0_valid", 32'(out_valid), 32'd1);
    chk("t1_issue0_cmd", 32'(out_cmd), 32'd1);
    chk("t1_issue0_word", 32'(out_word), 32'h0011);
    step();
    gap = 0;
    while (!out_valid && gap < 100) begin
      gap++;
      step();
    end
    chk("t1_gap", 32'(gap), 32'd21);
    chk("t1_issue1_cmd", 32'(out_cmd), 32'd1);
    chk("t1_issue1_word", 32'(out_word), 32'h0029);
    chk("t1_issue1_init_done", 32'(init_done), 32'd0);
    step();
    chk("t1_init_done", 32'(init_done), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);

    // T2: 2x2 fill, inputs scrambled after acceptance
    set_rect(9'd0, 9'd1, 9'd0, 9'd1, 16'h07E0);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    chk("t2_latency_valid", 32'(out_valid), 32'd1);
    set_rect(9'd100, 9'd200, 9'd7, 9'd9, 16'hDEAD);
    exp_words[0] = 16'h2A; exp_words[1] = 16'h00; exp_words[2]  = 16'h00;
    exp_words[3] = 16'h00; exp_words[4] = 16'h01; exp_words[5]  = 16'h2B;
    exp_words[6] = 16'h00; exp_words[7] = 16'h00; exp_words[8]  = 16'h00;
    exp_words[9] = 16'h01; exp_words[10] = 16'h2C;
    for (int i = 0; i < 11; i++)
      expect_word($sformatf("t2_w%0d", i), (i == 0 || i == 5 || i == 10), exp_words[i]);
    for (int i = 0; i < 4; i++)
      expect_word($sformatf("t2_p%0d", i), 1'b0, 16'h07E0);
    chk("t2_done_valid", 32'(out_valid), 32'd0);
    chk("t2_done_busy", 32'(busy), 32'd0);

    // T2b: coordinates with bit 8 set, 43x2 pixels
    set_rect(9'd258, 9'd300, 9'd3, 9'd4, 16'hA5A5);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    exp_words[0] = 16'h2A; exp_words[1] = 16'h01; exp_words[2]  = 16'h02;
    exp_words[3] = 16'h01; exp_words[4] = 16'h2C; exp_words[5]  = 16'h2B;
    exp_words[6] = 16'h00; exp_words[7] = 16'h03; exp_words[8]  = 16'h00;
    exp_words[9] = 16'h04; exp_words[10] = 16'h2C;
    for (int i = 0; i < 11; i++)
      expect_word($sformatf("t2b_w%0d", i), (i == 0 || i == 5 || i == 10), exp_words[i]);
    pix = 0;
    for (int c = 0; c < 500 && busy; c++) begin
      if (out_valid && out_ready && !out_cmd && out_word == 16'hA5A5) pix++;
      step();
    end
    chk("t2b_pix_count", 32'(pix), 32'd86);
    chk("t2b_busy", 32'(busy), 32'd0);

    // T3: rejected rectangles pulse fill_err for one cycle
    set_rect(9'd5, 9'd4, 9'd0, 9'd0, 16'h1111);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    chk("t3a_err", 32'(fill_err), 32'd1);
    chk("t3a_valid", 32'(out_valid), 32'd0);
    step();
    chk("t3a_err_pulse", 32'(fill_err), 32'd0);
    chk("t3a_valid2", 32'(out_valid), 32'd0);
    chk("t3a_busy", 32'(busy), 32'd0);
    set_rect(9'd0, 9'd320, 9'd0, 9'd0, 16'h1111);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    chk("t3b_err", 32'(fill_err), 32'd1);
    step();
    chk("t3b_err_pulse", 32'(fill_err), 32'd0);
    chk("t3b_valid", 32'(out_valid), 32'd0);
    set_rect(9'd0, 9'd0, 9'd0, 9'd24, 16'h1111);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    chk("t3c_err", 32'(fill_err), 32'd1);
    step();

    // T4: full-screen fill under random backpressure
    set_rect(9'd0, 9'd319, 9'd0, 9'd23, 16'hF81F);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    xfers = 0; pix = 0; bad = 0; prev_stall = 1'b0; pw = '0; pc = 1'b0;
    for (int c = 0; c < 40000 && busy; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (prev_stall && (!out_valid || out_word !== pw || out_cmd !== pc)) bad++;
      if (out_valid && out_ready) begin
        xfers++;
        if (!out_cmd && out_word == 16'hF81F) pix++;
      end
      prev_stall = out_valid && !out_ready;
      pw = out_word;
      pc = out_cmd;
      step();
    end
    out_ready = 1'b1;
    chk("t4_done", 32'(busy), 32'd0);
    chk("t4_xfers", 32'(xfers), 32'd7691);
    chk("t4_pix", 32'(pix), 32'd7680);
    chk("t4_stall_hold", 32'(bad), 32'd0);

    // T5: reset while in PIX
    set_rect(9'd0, 9'd3, 9'd0, 9'd3, 16'h5555);
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("t5_in_pix_valid", 32'(out_valid), 32'd1);
    chk("t5_in_pix_word", 32'(out_word), 32'h5555);
    res = 1'b1;
    step();
    res = 1'b0;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_word", 32'(out_word), 32'd0);
    chk("t5_rst_cmd", 32'(out_cmd), 32'd0);
    chk("t5_rst_init_done", 32'(init_done), 32'd0);
    chk("t5_rst_fill_err", 32'(fill_err), 32'd0);

    // T5: start_init beats a simultaneous fill_req
    init_done_wait: begin end
    set_rect(9'd0, 9'd1, 9'd0, 9'd1, 16'h7777);
    start_init = 1'b1;
    fill_req   = 1'b1;
    step();
    start_init = 1'b0;
    fill_req   = 1'b0;
    chk("t5_both_busy", 32'(busy), 32'd1);
    chk("t5_both_valid", 32'(out_valid), 32'd0);
    chk("t5_both_err", 32'(fill_err), 32'd0);
    step();
    chk("t5_both_word", 32'(out_word), 32'h0011);
    n_data = 0;
    for (int c = 0; c < 200 && !init_done; c++) begin
      if (out_valid && out_ready && !out_cmd) n_data++;
      step();
    end
    chk("t5_init_done", 32'(init_done), 32'd1);
    chk("t5_no_fill_data", 32'(n_data), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // start_init clears init_done until the script completes again
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    chk("t5_restart_clear", 32'(init_done), 32'd0);
    for (int c = 0; c < 200 && !init_done; c++) step();
    chk("t5_restart_done", 32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
